// File: rtl/gmac_tx_chan_src.sv
`default_nettype none
// ============================================================================
// Module : gmac_tx_chan_src
// Buffers whole user frames and bursts each one to a CustomGMAC input channel.
// Rev    : 1.0
// ============================================================================
module gmac_tx_chan_src #(
    parameter int ADDR_W  = 11,
    parameter int LEN_AW  = 2,
    parameter int MAX_LEN = 1472,
    parameter int GAP_CYC = 2
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            WR_EN,
    input  logic [7:0]      WR_DATA,
    input  logic            WR_LAST,
    output logic            WR_READY,
    output logic            WR_DROP,
    output logic            TX_REQ,
    input  logic            TX_CONFIRM,
    output logic            TX_VAL,
    output logic            TX_SOF,
    output logic            TX_EOF,
    output logic [7:0]      TX_DATA,
    output logic [LEN_AW:0] FRAMES_PENDING,
    output logic            BUSY
);

    localparam int c_len_w    = 11;
    localparam int c_lf_depth = 2**LEN_AW;
    localparam int c_gap_w    = (GAP_CYC < 2) ? 1 : $clog2(GAP_CYC);

    localparam logic [c_len_w-1:0] c_max_len  = c_len_w'(MAX_LEN);
    localparam logic [c_len_w-1:0] c_len_one  = c_len_w'(1);
    localparam logic [ADDR_W-1:0]  c_addr_one = ADDR_W'(1);
    localparam logic [LEN_AW:0]    c_lf_full  = (LEN_AW+1)'(c_lf_depth);
    localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_req  = 2'd1;
    localparam logic [1:0] c_send = 2'd2;
    localparam logic [1:0] c_gap  = 2'd3;

    logic [7:0]         mem [2**ADDR_W];
    logic [c_len_w-1:0] lf_mem [c_lf_depth];
    logic [7:0]         rd_data_q;

    logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d, wr_base_q, wr_base_d, rd_ptr_q, rd_ptr_d;
    logic [c_len_w-1:0] len_run_q, len_run_d, len_cnt_q, len_cnt_d;
    logic               bad_q, bad_d, drop_q, drop_d, rdy_en_q, rdy_en_d;
    logic [LEN_AW-1:0]  lf_wr_q, lf_wr_d, lf_rd_q, lf_rd_d;
    logic [LEN_AW:0]    lf_cnt_q, lf_cnt_d;
    logic [1:0]         state_q, state_d;
    logic [c_gap_w-1:0] gap_cnt_q, gap_cnt_d;
    logic               tx_req_q, tx_req_d, tx_val_q, tx_val_d;
    logic               tx_sof_q, tx_sof_d, tx_eof_q, tx_eof_d;
    logic [7:0]         tx_data_q, tx_data_d;

    logic w_buf_full, w_lf_full, w_bad, w_wr, w_push, w_pop;

    // Write side: bytes land speculatively; wr_base marks the uncommitted frame start.
    always_comb begin
        w_buf_full = (wr_ptr_q + c_addr_one) == rd_ptr_q;
        w_lf_full  = lf_cnt_q == c_lf_full;
        w_bad      = bad_q | w_buf_full | w_lf_full | (len_run_q == c_max_len);
        w_wr       = WR_EN & ~w_bad;
        w_push     = w_wr & WR_LAST;

        wr_ptr_d  = wr_ptr_q;
        wr_base_d = wr_base_q;
        len_run_d = len_run_q;
        bad_d     = bad_q;
        drop_d    = 1'b0;
        rdy_en_d  = 1'b1;

        if (WR_EN) begin
            if (w_bad) begin
                if (WR_LAST) begin
                    wr_ptr_d  = wr_base_q;
                    len_run_d = '0;
                    bad_d     = 1'b0;
                    drop_d    = 1'b1;
                end else begin
                    bad_d = 1'b1;
                end
            end else begin
                wr_ptr_d = wr_ptr_q + c_addr_one;
                if (WR_LAST) begin
                    wr_base_d = wr_ptr_q + c_addr_one;
                    len_run_d = '0;
                end else begin
                    len_run_d = len_run_q + c_len_one;
                end
            end
        end
    end

    // Read side; rd_ptr always addresses the byte currently held in rd_data_q.
    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        len_cnt_d = len_cnt_q;
        rd_ptr_d  = rd_ptr_q;
        tx_req_d  = tx_req_q;
        tx_val_d  = tx_val_q;
        tx_sof_d  = tx_sof_q;
        tx_eof_d  = tx_eof_q;
        tx_data_d = tx_data_q;
        w_pop     = 1'b0;

        case (state_q)
            c_idle: begin
                if (lf_cnt_q != '0) begin
                    w_pop     = 1'b1;
                    len_cnt_d = lf_mem[lf_rd_q];
                    tx_req_d  = 1'b1;
                    state_d   = c_req;
                end
            end
            c_req: begin
                if (TX_CONFIRM) begin
                    tx_req_d  = 1'b0;
                    tx_val_d  = 1'b1;
                    tx_sof_d  = 1'b1;
                    tx_eof_d  = (len_cnt_q == c_len_one);
                    tx_data_d = rd_data_q;
                    len_cnt_d = len_cnt_q - c_len_one;
                    rd_ptr_d  = rd_ptr_q + c_addr_one;
                    state_d   = c_send;
                end
            end
            c_send: begin
                tx_sof_d = 1'b0;
                // len_cnt counts bytes still to follow the one now on the bus.
                if (len_cnt_q == '0) begin
                    tx_val_d  = 1'b0;
                    tx_eof_d  = 1'b0;
                    tx_data_d = 8'h00;
                    gap_cnt_d = '0;
                    state_d   = (GAP_CYC == 0) ? c_idle : c_gap;
                end else begin
                    tx_eof_d  = (len_cnt_q == c_len_one);
                    tx_data_d = rd_data_q;
                    len_cnt_d = len_cnt_q - c_len_one;
                    rd_ptr_d  = rd_ptr_q + c_addr_one;
                end
            end
            c_gap: begin
                if (gap_cnt_q == c_gap_last) begin
                    state_d = c_idle;
                end else begin
                    gap_cnt_d = gap_cnt_q + c_gap_w'(1);
                end
            end
            default: state_d = c_idle;
        endcase
    end

    always_comb begin
        lf_wr_d  = w_push ? lf_wr_q + LEN_AW'(1) : lf_wr_q;
        lf_rd_d  = w_pop  ? lf_rd_q + LEN_AW'(1) : lf_rd_q;
        lf_cnt_d = lf_cnt_q;
        case ({w_push, w_pop})
            2'b10:   lf_cnt_d = lf_cnt_q + (LEN_AW+1)'(1);
            2'b01:   lf_cnt_d = lf_cnt_q - (LEN_AW+1)'(1);
            default: lf_cnt_d = lf_cnt_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (w_wr) begin
            mem[wr_ptr_q] <= WR_DATA;
        end
        if (w_push) begin
            lf_mem[lf_wr_q] <= len_run_q + c_len_one;
        end
        rd_data_q <= mem[rd_ptr_d];
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q  <= '0;
            wr_base_q <= '0;
            rd_ptr_q  <= '0;
            len_run_q <= '0;
            len_cnt_q <= '0;
            bad_q     <= 1'b0;
            drop_q    <= 1'b0;
            rdy_en_q  <= 1'b0;
            lf_wr_q   <= '0;
            lf_rd_q   <= '0;
            lf_cnt_q  <= '0;
            state_q   <= c_idle;
            gap_cnt_q <= '0;
            tx_req_q  <= 1'b0;
            tx_val_q  <= 1'b0;
            tx_sof_q  <= 1'b0;
            tx_eof_q  <= 1'b0;
            tx_data_q <= 8'h00;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            wr_base_q <= wr_base_d;
            rd_ptr_q  <= rd_ptr_d;
            len_run_q <= len_run_d;
            len_cnt_q <= len_cnt_d;
            bad_q     <= bad_d;
            drop_q    <= drop_d;
            rdy_en_q  <= rdy_en_d;
            lf_wr_q   <= lf_wr_d;
            lf_rd_q   <= lf_rd_d;
            lf_cnt_q  <= lf_cnt_d;
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
            tx_req_q  <= tx_req_d;
            tx_val_q  <= tx_val_d;
            tx_sof_q  <= tx_sof_d;
            tx_eof_q  <= tx_eof_d;
            tx_data_q <= tx_data_d;
        end
    end

    assign WR_READY       = rdy_en_q & ~w_buf_full & ~w_lf_full;
    assign WR_DROP        = drop_q;
    assign TX_REQ         = tx_req_q;
    assign TX_VAL         = tx_val_q;
    assign TX_SOF         = tx_sof_q;
    assign TX_EOF         = tx_eof_q;
    assign TX_DATA        = tx_data_q;
    assign FRAMES_PENDING = lf_cnt_q;
    assign BUSY           = state_q != c_idle;

endmodule
`default_nettype wire
